// File: rtl/huff_merge_ctrl_if.sv
// Handshake and data bundle for huff_merge_ctrl: start request, six symbol
// counts in, merge stream, completion and error status out.
interface huff_merge_ctrl_if;
  logic       start;
  logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
  logic       busy;
  logic       merge_valid;
  logic [3:0] merge_a;
  logic [3:0] merge_b;
  logic [3:0] merge_id;
  logic [8:0] merge_sum;
  logic       done;
  logic       err;

  modport master (
    output start, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    input  busy, merge_valid, merge_a, merge_b, merge_id, merge_sum, done, err
  );

  modport slave (
    input  start, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    output busy, merge_valid, merge_a, merge_b, merge_id, merge_sum, done, err
  );
endinterface

// File: rtl/huff_merge_ctrl.sv
// Huffman merge sequencer for six symbols: five scan/merge rounds over 11 slots.
// Optional count-sum check against TOTAL is enabled by defining HUFF_SUM_CHK_EN.
//
// state | meaning
// IDLE  | waiting for start, counts not yet latched
// SCAN  | visiting slots 1..11, tracking the two smallest active nodes
// MERGE | retiring min1/min2, creating internal node 6+step
// FIN   | one cycle to raise done and drop busy
module huff_merge_ctrl #(
  parameter int TOTAL = 100
) (
  input  logic            clk,
  input  logic            reset,
  huff_merge_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, MERGE, FIN} state_t;

  localparam logic [10:0] TOTAL11 = 11'(TOTAL);

  state_t      r_state;
  logic [2:0]  r_step;
  logic [3:0]  r_idx;
  logic [8:0]  r_w [1:11];
  logic [11:1] r_act;
  logic [3:0]  r_min1, r_min2;
  logic        r_have1, r_have2;
  logic        r_busy, r_valid, r_done;
  logic [3:0]  r_a, r_b, r_id;
  logic [8:0]  r_sum;

  logic        w_accept;
  logic        w_sum_ok;
  logic [8:0]  w_cur;
  logic [8:0]  w_msum;
  logic [3:0]  w_new_id;

  assign w_accept = (r_state == IDLE) && bus.start && !r_busy;
  assign w_cur    = r_w[r_idx];
  assign w_msum   = r_w[r_min1] + r_w[r_min2];
  assign w_new_id = 4'(r_step) + 4'd6;

`ifdef HUFF_SUM_CHK_EN
  logic [10:0] w_sum;
  logic        r_err;
  assign w_sum = 11'(bus.CNT1) + 11'(bus.CNT2) + 11'(bus.CNT3)
               + 11'(bus.CNT4) + 11'(bus.CNT5) + 11'(bus.CNT6);
  assign w_sum_ok = (w_sum == TOTAL11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_err <= 1'b0;
    else if (w_accept) r_err <= !w_sum_ok;
  end
  assign bus.err = r_err;
`else
  logic w_unused_total;
  assign w_unused_total = ^TOTAL11;
  assign w_sum_ok = 1'b1;
  assign bus.err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_idx   <= '0;
      for (int i = 1; i <= 11; i++) r_w[i] <= '0;
      r_act   <= '0;
      r_min1  <= '0;
      r_min2  <= '0;
      r_have1 <= 1'b0;
      r_have2 <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= '0;
      r_sum   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (w_accept) begin
            r_busy <= 1'b1;
            if (!w_sum_ok) begin
              // Rejected request: done and busy share the single following cycle.
              r_done <= 1'b1;
            end else begin
              r_w[1] <= {1'b0, bus.CNT1};
              r_w[2] <= {1'b0, bus.CNT2};
              r_w[3] <= {1'b0, bus.CNT3};
              r_w[4] <= {1'b0, bus.CNT4};
              r_w[5] <= {1'b0, bus.CNT5};
              r_w[6] <= {1'b0, bus.CNT6};
              for (int i = 7; i <= 11; i++) r_w[i] <= '0;
              r_act   <= 11'h03F;
              r_step  <= 3'd1;
              r_idx   <= 4'd1;
              r_have1 <= 1'b0;
              r_have2 <= 1'b0;
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          // Ascending slot order makes strict '<' resolve weight ties to the lower ID.
          if (r_act[r_idx]) begin
            if (!r_have1 || (w_cur < r_w[r_min1])) begin
              r_min2  <= r_min1;
              r_have2 <= r_have1;
              r_min1  <= r_idx;
              r_have1 <= 1'b1;
            end else if (!r_have2 || (w_cur < r_w[r_min2])) begin
              r_min2  <= r_idx;
              r_have2 <= 1'b1;
            end
          end
          if (r_idx == 4'd11) r_state <= MERGE;
          else                r_idx   <= r_idx + 4'd1;
        end
        MERGE: begin
          r_act[r_min1]    <= 1'b0;
          r_act[r_min2]    <= 1'b0;
          r_act[w_new_id]  <= 1'b1;
          r_w[w_new_id]    <= w_msum;
          r_a     <= r_min1;
          r_b     <= r_min2;
          r_id    <= w_new_id;
          r_sum   <= w_msum;
          r_valid <= 1'b1;
          r_step  <= r_step + 3'd1;
          if (r_step < 3'd5) begin
            r_idx   <= 4'd1;
            r_have1 <= 1'b0;
            r_have2 <= 1'b0;
            r_state <= SCAN;
          end else begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.merge_valid = r_valid;
  assign bus.merge_a     = r_a;
  assign bus.merge_b     = r_b;
  assign bus.merge_id    = r_id;
  assign bus.merge_sum   = r_sum;
  assign bus.done        = r_done;

endmodule
